// File: rtl/pipe_scroller_if.sv
// Signal bundle between the pipe scroller and the game datapath: frame/control
// inputs, random-height handshake, and pipe/score outputs.
interface pipe_scroller_if;
  logic        frame_tick;
  logic        start;
  logic        stop;
  logic [15:0] rand_height;
  logic        rand_req;
  logic [10:0] pipe0_x;
  logic [15:0] pipe0_gap_y;
  logic [10:0] pipe1_x;
  logic [15:0] pipe1_gap_y;
  logic        running;
  logic [9:0]  score;
  logic        score_pulse;

  modport master (
    output frame_tick, start, stop, rand_height,
    input  rand_req, pipe0_x, pipe0_gap_y, pipe1_x, pipe1_gap_y,
           running, score, score_pulse
  );

  modport slave (
    input  frame_tick, start, stop, rand_height,
    output rand_req, pipe0_x, pipe0_gap_y, pipe1_x, pipe1_gap_y,
           running, score, score_pulse
  );
endinterface

// File: rtl/pipe_scroller.sv
// Scrolls two pipes once per frame, wraps them at the left edge, fetches new gap
// heights through a single-outstanding request FSM, and counts pipes passed.
module pipe_scroller #(
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned PIPE_W      = 80,
  parameter int unsigned SPEED       = 2,
  parameter int unsigned BIRD_X      = 200,
  parameter int unsigned GAP_DEFAULT = 220
) (
  input  logic            clk,
  input  logic            reset,
  pipe_scroller_if.slave  bus
);

  localparam int unsigned LOOP      = SCREEN_W + PIPE_W;
  localparam logic [10:0] X0_INIT   = 11'(LOOP);
  localparam logic [10:0] X1_INIT   = 11'(LOOP + LOOP / 2);
  localparam logic [10:0] STEP      = 11'(SPEED);
  localparam logic [10:0] WRAP_ADD  = 11'(LOOP - SPEED);
  localparam logic [10:0] BIRD      = 11'(BIRD_X);
  localparam logic [15:0] GAP_INIT  = 16'(GAP_DEFAULT);
  localparam logic [9:0]  SCORE_MAX = 10'd999;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FROZEN} state_t;
  typedef enum logic [1:0] {F_IDLE, F_REQ, F_CAP}    fetch_t;

  state_t      r_state, w_state_next;
  fetch_t      r_fetch, w_fetch_next;
  logic [10:0] r_x0, r_x1;
  logic [15:0] r_gap0, r_gap1;
  logic [9:0]  r_score;
  logic        r_score_pulse;
  logic        r_pend0, r_pend1;
  logic        r_sel;

  logic        w_restart, w_move;
  logic        w_pick, w_pick_sel, w_req, w_cap;
  logic [10:0] w_x0_mv, w_x1_mv;
  logic        w_wrap0, w_wrap1, w_cross;

  // Wrap adds LOOP-SPEED so the two pipes keep their exact half-loop spacing.
  function automatic logic [10:0] f_move(input logic [10:0] x);
    return (x > STEP) ? x - STEP : x + WRAP_ADD;
  endfunction

  always_comb begin
    w_state_next = r_state;
    w_restart    = 1'b0;
    case (r_state)
      S_IDLE:   if (bus.start) begin w_state_next = S_RUN; w_restart = 1'b1; end
      S_RUN:    if (bus.stop)  w_state_next = S_FROZEN;
      S_FROZEN: if (bus.start) begin w_state_next = S_RUN; w_restart = 1'b1; end
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_move  = (r_state == S_RUN) && bus.frame_tick;
    w_x0_mv = f_move(r_x0);
    w_x1_mv = f_move(r_x1);
    w_wrap0 = (r_x0 <= STEP);
    w_wrap1 = (r_x1 <= STEP);
    w_cross = ((r_x0 >= BIRD) && (w_x0_mv < BIRD)) ||
              ((r_x1 >= BIRD) && (w_x1_mv < BIRD));
  end

  always_comb begin
    w_fetch_next = r_fetch;
    w_pick       = 1'b0;
    w_pick_sel   = 1'b0;
    w_req        = 1'b0;
    w_cap        = 1'b0;
    case (r_fetch)
      F_IDLE: if (r_pend0 || r_pend1) begin
        w_pick       = 1'b1;
        w_pick_sel   = !r_pend0;
        w_fetch_next = F_REQ;
      end
      F_REQ: begin
        w_req        = 1'b1;
        w_fetch_next = F_CAP;
      end
      F_CAP: begin
        w_cap        = 1'b1;
        w_fetch_next = F_IDLE;
      end
      default: w_fetch_next = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_fetch       <= F_IDLE;
      r_x0          <= X0_INIT;
      r_x1          <= X1_INIT;
      r_gap0        <= GAP_INIT;
      r_gap1        <= GAP_INIT;
      r_score       <= '0;
      r_score_pulse <= 1'b0;
      r_pend0       <= 1'b0;
      r_pend1       <= 1'b0;
      r_sel         <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_fetch       <= w_fetch_next;
      r_score_pulse <= 1'b0;
      if (w_pick) begin
        r_sel <= w_pick_sel;
        if (!w_pick_sel) r_pend0 <= 1'b0;
        else             r_pend1 <= 1'b0;
      end
      // Flag sets come after the pick clear so a same-cycle request is not lost.
      if (w_restart) begin
        r_x0    <= X0_INIT;
        r_x1    <= X1_INIT;
        r_gap0  <= GAP_INIT;
        r_gap1  <= GAP_INIT;
        r_score <= '0;
        r_pend0 <= 1'b1;
        r_pend1 <= 1'b1;
      end else if (w_move) begin
        r_x0 <= w_x0_mv;
        r_x1 <= w_x1_mv;
        if (w_wrap0) r_pend0 <= 1'b1;
        if (w_wrap1) r_pend1 <= 1'b1;
        if (w_cross) begin
          r_score_pulse <= 1'b1;
          if (r_score != SCORE_MAX) r_score <= r_score + 10'd1;
        end
      end
      if (w_cap) begin
        if (!r_sel) r_gap0 <= bus.rand_height;
        else        r_gap1 <= bus.rand_height;
      end
    end
  end

  assign bus.rand_req    = w_req;
  assign bus.pipe0_x     = r_x0;
  assign bus.pipe1_x     = r_x1;
  assign bus.pipe0_gap_y = r_gap0;
  assign bus.pipe1_gap_y = r_gap1;
  assign bus.running     = (r_state == S_RUN);
  assign bus.score       = r_score;
  assign bus.score_pulse = r_score_pulse;

endmodule

// File: tb/tb_pipe_scroller.sv
// Bench for pipe_scroller: a default-geometry and a shrunken-geometry instance
// share stimulus; a reference model queues expected outputs for a monitor.
module tb_pipe_scroller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipe_scroller_if ifa ();
  pipe_scroller_if ifb ();

  pipe_scroller dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  pipe_scroller #(.SCREEN_W(20), .PIPE_W(4), .SPEED(2), .BIRD_X(10), .GAP_DEFAULT(220))
    dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  typedef struct {
    int mst;   // 0 idle, 1 run, 2 frozen
    int x0, x1, g0, g1, score;
    int fph;   // 0 idle, 1 request cycle, 2 capture cycle
    int sel;
    bit pulse, p0, p1;
  } mdl_t;

  typedef struct {
    int x0, x1, g0, g1, score;
    bit running, pulse, req;
  } snap_t;

  mdl_t  ma, mb;
  snap_t qa[$], qb[$];
  int    checks = 0;
  int    failures = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void mreset(inout mdl_t m, input int loop, input int gdef);
    m.mst = 0; m.x0 = loop; m.x1 = loop + loop / 2; m.g0 = gdef; m.g1 = gdef;
    m.score = 0; m.fph = 0; m.sel = 0; m.pulse = 0; m.p0 = 0; m.p1 = 0;
  endfunction

  function automatic void madv(inout mdl_t m, input int loop, input int spd, input int bird,
                               input int gdef, input bit ft, input bit st, input bit sp,
                               input int rh);
    bit restart, move, cap, crossed;
    int csel, nx;
    restart = (m.mst != 1) && st;
    move    = (m.mst == 1) && ft;
    cap     = (m.fph == 2);
    csel    = m.sel;
    crossed = 0;
    m.pulse = 0;
    if (m.fph == 0 && (m.p0 || m.p1)) begin
      m.sel = m.p0 ? 0 : 1;
      if (m.p0) m.p0 = 0; else m.p1 = 0;
      m.fph = 1;
    end else if (m.fph == 1) m.fph = 2;
    else if (m.fph == 2) m.fph = 0;
    if (restart) begin
      m.x0 = loop; m.x1 = loop + loop / 2; m.g0 = gdef; m.g1 = gdef;
      m.score = 0; m.p0 = 1; m.p1 = 1;
    end else if (move) begin
      nx = (m.x0 > spd) ? m.x0 - spd : m.x0 + loop - spd;
      if (m.x0 <= spd) m.p0 = 1;
      if (m.x0 >= bird && nx < bird) crossed = 1;
      m.x0 = nx;
      nx = (m.x1 > spd) ? m.x1 - spd : m.x1 + loop - spd;
      if (m.x1 <= spd) m.p1 = 1;
      if (m.x1 >= bird && nx < bird) crossed = 1;
      m.x1 = nx;
      if (crossed) begin
        m.pulse = 1;
        if (m.score < 999) m.score++;
      end
    end
    if (cap) begin
      if (csel == 0) m.g0 = rh; else m.g1 = rh;
    end
    if (m.mst == 1 && sp) m.mst = 2;
    else if (restart) m.mst = 1;
  endfunction

  function automatic snap_t msnap(input mdl_t m);
    snap_t s;
    s.x0 = m.x0; s.x1 = m.x1; s.g0 = m.g0; s.g1 = m.g1; s.score = m.score;
    s.running = (m.mst == 1); s.pulse = m.pulse; s.req = (m.fph == 1);
    return s;
  endfunction

  function automatic void cmp_snap(string tag, snap_t a, snap_t e);
    chk({tag, ".pipe0_x"},     a.x0,      e.x0);
    chk({tag, ".pipe1_x"},     a.x1,      e.x1);
    chk({tag, ".pipe0_gap_y"}, a.g0,      e.g0);
    chk({tag, ".pipe1_gap_y"}, a.g1,      e.g1);
    chk({tag, ".score"},       a.score,   e.score);
    chk({tag, ".running"},     a.running, e.running);
    chk({tag, ".score_pulse"}, a.pulse,   e.pulse);
    chk({tag, ".rand_req"},    a.req,     e.req);
  endfunction

  task automatic step(input bit rst, input bit ft, input bit st, input bit sp, input int rh);
    @(negedge clk);
    reset = rst;
    ifa.frame_tick = ft; ifa.start = st; ifa.stop = sp; ifa.rand_height = 16'(rh);
    ifb.frame_tick = ft; ifb.start = st; ifb.stop = sp; ifb.rand_height = 16'(rh);
    if (rst) begin
      mreset(ma, 720, 220);
      mreset(mb, 24, 220);
    end else begin
      madv(ma, 720, 2, 200, 220, ft, st, sp, rh);
      madv(mb, 24, 2, 10, 220, ft, st, sp, rh);
    end
    qa.push_back(msnap(ma));
    qb.push_back(msnap(mb));
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  function automatic int rnd_h();
    return 220 + 10 * int'($urandom_range(0, 22));
  endfunction

  // Monitor: every output cycle is compared against the queued prediction.
  initial begin
    snap_t a, e;
    forever begin
      @(posedge clk);
      #2;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        a.x0 = ifa.pipe0_x; a.x1 = ifa.pipe1_x; a.g0 = ifa.pipe0_gap_y; a.g1 = ifa.pipe1_gap_y;
        a.score = ifa.score; a.running = ifa.running; a.pulse = ifa.score_pulse; a.req = ifa.rand_req;
        cmp_snap("A", a, e);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        a.x0 = ifb.pipe0_x; a.x1 = ifb.pipe1_x; a.g0 = ifb.pipe0_gap_y; a.g1 = ifb.pipe1_gap_y;
        a.score = ifb.score; a.running = ifb.running; a.pulse = ifb.score_pulse; a.req = ifb.rand_req;
        cmp_snap("B", a, e);
      end
    end
  end

  initial begin
    ifa.frame_tick = 0; ifa.start = 0; ifa.stop = 0; ifa.rand_height = 16'd0;
    ifb.frame_tick = 0; ifb.start = 0; ifb.stop = 0; ifb.rand_height = 16'd0;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    settle();
    chk("reset.pipe1_x", int'(ifa.pipe1_x), 1080);

    // Start: two fetches, pipe0 latches 300, pipe1 latches 410.
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 300);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 410);
    settle();
    chk("start.gap0", int'(ifa.pipe0_gap_y), 300);
    chk("start.gap1", int'(ifa.pipe1_gap_y), 410);

    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 0, rnd_h());
      step(0, 0, 0, 0, rnd_h());
      step(0, 0, 0, 0, rnd_h());
    end
    settle();
    chk("ticks10.pipe0_x", int'(ifa.pipe0_x), 700);
    chk("ticks10.pipe1_x", int'(ifa.pipe1_x), 1060);

    // Stop freezes; restart reinitialises.
    step(0, 0, 0, 1, rnd_h());
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, rnd_h());
    settle();
    chk("frozen.pipe0_x", int'(ifa.pipe0_x), 700);
    chk("frozen.running", int'(ifa.running), 0);
    step(0, 0, 1, 1, rnd_h());
    settle();
    chk("restart.pipe0_x", int'(ifa.pipe0_x), 720);
    chk("restart.running", int'(ifa.running), 1);

    // Reset while the first fetch is in its request cycle.
    step(0, 0, 0, 0, 330);
    settle();
    chk("preabort.rand_req", int'(ifa.rand_req), 1);
    step(1, 0, 0, 0, 330);
    step(0, 0, 0, 0, 330);
    settle();
    chk("abort.rand_req", int'(ifa.rand_req), 0);
    chk("abort.gap0", int'(ifa.pipe0_gap_y), 220);

    // Start and stop together while running: stop wins.
    step(0, 0, 1, 0, rnd_h());
    step(0, 1, 1, 1, rnd_h());
    settle();
    chk("startstop.running", int'(ifa.running), 0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 49) == 0), rnd_h());
    end

    // Long uninterrupted run drives the small instance into score saturation.
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, rnd_h());
    for (int i = 0; i < 9000; i++) step(0, ($urandom_range(0, 4) != 0), 0, 0, rnd_h());
    settle();
    chk("sat.score", int'(ifb.score), 999);

    step(0, 0, 0, 0, 0);
    settle();
    settle();
    chk("queue_drain", qa.size() + qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
